// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared constants and FSM state encoding for the
// bit-serial subtractor.
package serial_sub_pkg;

  // Operand/result width used when the parent does not override WIDTH.
  localparam int DEFAULT_WIDTH = 8;

  // Controller states; encoding 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_cell.sv
// full_sub_cell: one-bit full subtractor, d = a - b - bin with borrow out.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_axb;

  assign w_axb = a ^ b;
  assign d     = w_axb ^ bin;
  // Borrow when b exceeds a, or when a equals b and a borrow is pending.
  assign bout  = (~a & b) | (~w_axb & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: computes a-b (mod 2^WIDTH) one bit per clock, LSB first.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Bit counter only needs to reach WIDTH-1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic             r_bor;
  logic [CW-1:0]    r_cnt;
  logic             w_d;
  logic             w_bout;
  logic             w_last;

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  full_sub_cell u_cell (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_bor),
    .d    (w_d),
    .bout (w_bout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: accept in IDLE, run WIDTH steps, one DONE cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = SHIFT;
        end else begin
          w_next = IDLE;
        end
      end
      SHIFT: begin
        if (w_last) begin
          w_next = DONE;
        end else begin
          w_next = SHIFT;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: load on accepted start, then one subtract step per SHIFT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_diff <= '0;
      r_bor  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a    <= a;
            r_b    <= b;
            r_diff <= '0;
            r_bor  <= 1'b0;
            r_cnt  <= '0;
          end
        end
        SHIFT: begin
          r_diff <= {w_d, r_diff[WIDTH-1:1]};
          r_a    <= {1'b0, r_a[WIDTH-1:1]};
          r_b    <= {1'b0, r_b[WIDTH-1:1]};
          r_bor  <= w_bout;
          r_cnt  <= r_cnt + CW'(1);
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_ovf;

  // Signed overflow: borrow into the MSB step differs from borrow out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if ((r_state == IDLE) && start) begin
      r_ovf <= 1'b0;
    end else if ((r_state == SHIFT) && w_last) begin
      r_ovf <= r_bor ^ w_bout;
    end
  end

  assign ovf = r_ovf;
`endif

  assign busy       = (r_state == SHIFT);
  assign done       = (r_state == DONE);
  assign diff       = r_diff;
  assign borrow_out = r_bor;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=4 instances).
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start4;
  logic [7:0] a8, b8, diff8;
  logic [3:0] a4, b4, diff4;
  logic       busy8, done8, bo8;
  logic       busy4, done4, bo4;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf8, ovf4;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf4)
`endif
  );

  // Reference model: plain modular arithmetic and sign rules.
  function automatic logic [7:0] m_diff(input int w, input int x, input int y);
    int mask;
    mask = (1 << w) - 1;
    return 8'((x - y) & mask);
  endfunction

  function automatic logic m_bor(input int x, input int y);
    return (x < y);
  endfunction

  function automatic logic m_ovf(input int w, input int x, input int y);
    int d, sx, sy, sd;
    d  = (x - y) & ((1 << w) - 1);
    sx = (x >> (w - 1)) & 1;
    sy = (y >> (w - 1)) & 1;
    sd = (d >> (w - 1)) & 1;
    return (sx != sy) && (sd != sx);
  endfunction

  // Run one operation; returns results at the done cycle plus latency in edges.
  task automatic run_op(input bit sel4, input logic [7:0] ia, input logic [7:0] ib,
                        output logic [7:0] od, output logic obo, output logic oov,
                        output int olat, output int obusy);
    od = 8'h00; obo = 1'b0; oov = 1'b0; olat = -1; obusy = 0;
    @(negedge clk);
    if (sel4) begin start4 = 1'b1; a4 = ia[3:0]; b4 = ib[3:0]; end
    else      begin start8 = 1'b1; a8 = ia;      b8 = ib;      end
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start4 = 1'b0; start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom);
      a4 = 4'($urandom); b4 = 4'($urandom);
      if (sel4 ? busy4 : busy8) obusy++;
      if (sel4 ? done4 : done8) begin
        olat = n;
        od   = sel4 ? {4'h0, diff4} : diff8;
        obo  = sel4 ? bo4 : bo8;
`ifdef SERIAL_SUB_OVF_EN
        oov  = sel4 ? ovf4 : ovf8;
`endif
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; a4 = 4'h0; b4 = 4'h0;
    repeat (2) @(negedge clk);
    tests++; if ({busy8, done8, bo8, diff8} !== 11'd0) begin
      fails++; $display("FAIL reset8 got busy=%b done=%b bo=%b diff=%h want all 0", busy8, done8, bo8, diff8); end
    tests++; if ({busy4, done4, bo4, diff4} !== 7'd0) begin
      fails++; $display("FAIL reset4 got busy=%b done=%b bo=%b diff=%h want all 0", busy4, done4, bo4, diff4); end
`ifdef SERIAL_SUB_OVF_EN
    tests++; if ({ovf8, ovf4} !== 2'b00) begin
      fails++; $display("FAIL reset_ovf got %b%b want 00", ovf8, ovf4); end
`endif
    rst = 1'b0;
  endtask

  // Check one WIDTH=8 result against the model.
  task automatic test_op8(input string tag, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] d; logic bo, ov; int lat, bc;
    run_op(1'b0, x, y, d, bo, ov, lat, bc);
    tests++; if (lat !== 9) begin fails++; $display("FAIL %s_latency a=%h b=%h got %0d want 9", tag, x, y, lat); end
    tests++; if (bc !== 8) begin fails++; $display("FAIL %s_busy_cycles a=%h b=%h got %0d want 8", tag, x, y, bc); end
    tests++; if (d !== m_diff(8, int'(x), int'(y))) begin
      fails++; $display("FAIL %s_diff a=%h b=%h got %h want %h", tag, x, y, d, m_diff(8, int'(x), int'(y))); end
    tests++; if (bo !== m_bor(int'(x), int'(y))) begin
      fails++; $display("FAIL %s_borrow a=%h b=%h got %b want %b", tag, x, y, bo, m_bor(int'(x), int'(y))); end
`ifdef SERIAL_SUB_OVF_EN
    tests++; if (ov !== m_ovf(8, int'(x), int'(y))) begin
      fails++; $display("FAIL %s_ovf a=%h b=%h got %b want %b", tag, x, y, ov, m_ovf(8, int'(x), int'(y))); end
`endif
  endtask

  task automatic test_directed();
    logic [7:0] ta[8] = '{8'h05, 8'h03, 8'h00, 8'h00, 8'h80, 8'h7F, 8'h10, 8'hFF};
    logic [7:0] tb[8] = '{8'h03, 8'h05, 8'hFF, 8'h00, 8'h01, 8'hFF, 8'h01, 8'h00};
    for (int i = 0; i < 8; i++) test_op8("directed", ta[i], tb[i]);
  endtask

  task automatic test_hold();
    test_op8("hold_op", 8'h3C, 8'hC3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom);
      tests++; if ({busy8, done8} !== 2'b00) begin
        fails++; $display("FAIL hold_flags got busy=%b done=%b want 0 0", busy8, done8); end
      tests++; if ({bo8, diff8} !== {1'b1, 8'h79}) begin
        fails++; $display("FAIL hold_value got bo=%b diff=%h want 1 79", bo8, diff8); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) test_op8("random", 8'($urandom), 8'($urandom));
  endtask

  task automatic test_back_to_back();
    logic [7:0] opa[0:30];
    logic [7:0] opb[0:30];
    int dn[3] = '{-1, -1, -1};
    logic [7:0] rd[3];
    logic rb[3];
    int k = 0;
    @(negedge clk);
    start8 = 1'b1;
    opa[0] = 8'($urandom); opb[0] = 8'($urandom);
    a8 = opa[0]; b8 = opb[0];
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (done8 && k < 3) begin dn[k] = n; rd[k] = diff8; rb[k] = bo8; k++; end
      opa[n] = 8'($urandom); opb[n] = 8'($urandom);
      a8 = opa[n]; b8 = opb[n];
    end
    start8 = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tests++; if (dn[j] !== 9 + 10 * j) begin
        fails++; $display("FAIL b2b_done_edge%0d got %0d want %0d", j, dn[j], 9 + 10 * j); end
      tests++; if ({rb[j], rd[j]} !== {m_bor(int'(opa[10*j]), int'(opb[10*j])), m_diff(8, int'(opa[10*j]), int'(opb[10*j]))}) begin
        fails++; $display("FAIL b2b_result%0d got bo=%b diff=%h want bo=%b diff=%h", j, rb[j], rd[j],
                          m_bor(int'(opa[10*j]), int'(opb[10*j])), m_diff(8, int'(opa[10*j]), int'(opb[10*j]))); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int ndone = 0;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h11;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      start8 = 1'b0;
    end
    tests++; if (busy8 !== 1'b1) begin fails++; $display("FAIL abort_pre_busy got %b want 1", busy8); end
    rst = 1'b1;
    #1;
    tests++; if ({busy8, done8, bo8, diff8} !== 11'd0) begin
      fails++; $display("FAIL abort_async got busy=%b done=%b bo=%b diff=%h want all 0", busy8, done8, bo8, diff8); end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done8 || busy8) ndone++;
    end
    tests++; if (ndone !== 0) begin fails++; $display("FAIL abort_no_done got %0d active cycles want 0", ndone); end
    test_op8("after_abort", 8'h09, 8'h04);
  endtask

  task automatic test_exhaustive4();
    logic [7:0] d; logic bo, ov; int lat, bc;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        run_op(1'b1, 8'(x), 8'(y), d, bo, ov, lat, bc);
        tests++; if ({lat, bc} !== {32'd5, 32'd4}) begin
          fails++; $display("FAIL w4_timing a=%0d b=%0d got lat=%0d busy=%0d want 5 4", x, y, lat, bc); end
        tests++; if ({bo, d} !== {m_bor(x, y), m_diff(4, x, y)}) begin
          fails++; $display("FAIL w4_result a=%0d b=%0d got bo=%b diff=%h want bo=%b diff=%h", x, y, bo, d, m_bor(x, y), m_diff(4, x, y)); end
`ifdef SERIAL_SUB_OVF_EN
        tests++; if (ov !== m_ovf(4, x, y)) begin
          fails++; $display("FAIL w4_ovf a=%0d b=%0d got %b want %b", x, y, ov, m_ovf(4, x, y)); end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_random();
    test_back_to_back();
    test_reset_abort();
    test_exhaustive4();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
